// File: rtl/l2_noc2_arb_pkg.sv
// rtl/l2_noc2_arb_pkg.sv - shared types and constants for the L2 NoC2 output arbiter
package l2_noc2_arb_pkg;

  localparam int DEFAULT_FLIT_W = 64;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK1 = 2'd1,
    LOCK2 = 2'd2
  } arb_state_t;

  localparam logic [1:0] ARB_OWNER_NONE = 2'b00;
  localparam logic [1:0] ARB_OWNER_P1   = 2'b01;
  localparam logic [1:0] ARB_OWNER_P2   = 2'b10;

endpackage

// File: rtl/l2_noc2_out_arb_if.sv
// rtl/l2_noc2_out_arb_if.sv - pipe1/pipe2 input streams and NoC2 output stream of the arbiter
interface l2_noc2_out_arb_if
  import l2_noc2_arb_pkg::*;
#(
  parameter int FLIT_W = DEFAULT_FLIT_W
);
  logic              pipe1_valid;
  logic [FLIT_W-1:0] pipe1_data;
  logic              pipe1_last;
  logic              pipe1_ready;
  logic              pipe2_valid;
  logic [FLIT_W-1:0] pipe2_data;
  logic              pipe2_last;
  logic              pipe2_ready;
  logic              noc2_valid_out;
  logic [FLIT_W-1:0] noc2_data_out;
  logic              noc2_ready_out;

  modport master (
    output pipe1_valid, pipe1_data, pipe1_last,
    input  pipe1_ready,
    output pipe2_valid, pipe2_data, pipe2_last,
    input  pipe2_ready,
    input  noc2_valid_out, noc2_data_out,
    output noc2_ready_out
  );

  modport slave (
    input  pipe1_valid, pipe1_data, pipe1_last,
    output pipe1_ready,
    input  pipe2_valid, pipe2_data, pipe2_last,
    output pipe2_ready,
    output noc2_valid_out, noc2_data_out,
    input  noc2_ready_out
  );
endinterface

// File: rtl/l2_noc2_out_reg.sv
// rtl/l2_noc2_out_reg.sv - single-entry registered output stage toward NoC2
module l2_noc2_out_reg
  import l2_noc2_arb_pkg::*;
#(
  parameter int FLIT_W = DEFAULT_FLIT_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load,
  input  logic [FLIT_W-1:0] load_data,
  input  logic              ready_out,
  output logic              space,
  output logic              valid_out,
  output logic [FLIT_W-1:0] data_out
);

  // A draining entry frees its slot in the same cycle, so drain and load overlap.
  assign space = !valid_out || ready_out;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_out <= 1'b0;
      data_out  <= '0;
    end else if (load) begin
      valid_out <= 1'b1;
      data_out  <= load_data;
    end else if (ready_out) begin
      valid_out <= 1'b0;
    end
  end

endmodule

// File: rtl/l2_noc2_out_arb.sv
// rtl/l2_noc2_out_arb.sv - message-atomic arbiter of pipe1/pipe2 onto the L2 NoC2 output port
module l2_noc2_out_arb
  import l2_noc2_arb_pkg::*;
#(
  parameter int FLIT_W     = DEFAULT_FLIT_W,
  parameter int STARVE_MAX = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  l2_noc2_out_arb_if.slave    bus,
  output logic [1:0]          arb_owner,
  output logic [15:0]         msg_sent_cnt
);

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  arb_state_t        state;
  arb_state_t        state_nxt;
  logic [3:0]        starve_cnt;
  logic              space;
  logic              win1;
  logic              win2;
  logic              ready1;
  logic              ready2;
  logic              acc1;
  logic              acc2;
  logic              load;
  logic [FLIT_W-1:0] load_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    arb_owner = ARB_OWNER_NONE;
    win1      = 1'b0;
    win2      = 1'b0;
    ready1    = 1'b0;
    ready2    = 1'b0;
    // pipe2 wins ties unless pipe1 has hit its starvation bound
    if (bus.pipe1_valid && (!bus.pipe2_valid || starve_cnt == STARVE_LIM)) win1 = 1'b1;
    else if (bus.pipe2_valid)                                               win2 = 1'b1;
    case (state)
      IDLE: begin
        ready1 = win1 && space;
        ready2 = win2 && space;
      end
      LOCK1: begin
        ready1    = space;
        arb_owner = ARB_OWNER_P1;
      end
      LOCK2: begin
        ready2    = space;
        arb_owner = ARB_OWNER_P2;
      end
      default: ;
    endcase
    if (!rst_n) begin
      ready1 = 1'b0;
      ready2 = 1'b0;
    end
    acc1 = bus.pipe1_valid && ready1;
    acc2 = bus.pipe2_valid && ready2;
    case (state)
      IDLE: begin
        if (acc1 && !bus.pipe1_last)      state_nxt = LOCK1;
        else if (acc2 && !bus.pipe2_last) state_nxt = LOCK2;
      end
      LOCK1: if (acc1 && bus.pipe1_last) state_nxt = IDLE;
      LOCK2: if (acc2 && bus.pipe2_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.pipe1_ready = ready1;
  assign bus.pipe2_ready = ready2;
  assign load            = acc1 || acc2;
  assign load_data       = acc1 ? bus.pipe1_data : bus.pipe2_data;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      starve_cnt <= 4'd0;
    end else if (state == IDLE) begin
      if (acc1)                                                   starve_cnt <= 4'd0;
      else if (acc2 && bus.pipe1_valid && starve_cnt < STARVE_LIM) starve_cnt <= starve_cnt + 4'd1;
    end
  end

  // Counted at the arbiter input, so a message still in the output register is already counted.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) msg_sent_cnt <= 16'd0;
    else if ((acc1 && bus.pipe1_last) || (acc2 && bus.pipe2_last))
      msg_sent_cnt <= msg_sent_cnt + 16'd1;
  end

  l2_noc2_out_reg #(.FLIT_W(FLIT_W)) u_out_reg (
    .clk       (clk),
    .rst_n     (rst_n),
    .load      (load),
    .load_data (load_data),
    .ready_out (bus.noc2_ready_out),
    .space     (space),
    .valid_out (bus.noc2_valid_out),
    .data_out  (bus.noc2_data_out)
  );

endmodule

// File: tb/tb_l2_noc2_out_arb.sv
// tb/tb_l2_noc2_out_arb.sv - scoreboard bench for l2_noc2_out_arb
module tb_l2_noc2_out_arb;
  localparam int W = 64;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [1:0]  arb_owner;
  logic [15:0] msg_sent_cnt;

  l2_noc2_out_arb_if #(.FLIT_W(W)) bus ();

  l2_noc2_out_arb #(.FLIT_W(W), .STARVE_MAX(4)) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .arb_owner    (arb_owner),
    .msg_sent_cnt (msg_sent_cnt)
  );

  always #5 clk = ~clk;

  logic [W:0]   p1_q[$];
  logic [W:0]   p2_q[$];
  logic [W-1:0] exp_q[$];
  logic [W-1:0] obs_q[$];
  int           grant_q[$];
  int           grant_cyc[$];
  int           checks = 0;
  int           failures = 0;
  int           cyc = 0;
  logic         s_valid, s_r1, s_r2, s_p2v;
  logic [W-1:0] s_data;

  task automatic drive();
    bus.pipe1_valid = (p1_q.size() != 0);
    {bus.pipe1_last, bus.pipe1_data} = '0;
    if (p1_q.size() != 0) {bus.pipe1_last, bus.pipe1_data} = p1_q[0];
    bus.pipe2_valid = (p2_q.size() != 0);
    {bus.pipe2_last, bus.pipe2_data} = '0;
    if (p2_q.size() != 0) {bus.pipe2_last, bus.pipe2_data} = p2_q[0];
  endtask

  task automatic tick();
    logic t1, t2;
    @(negedge clk);
    t1 = bus.pipe1_valid && bus.pipe1_ready;
    t2 = bus.pipe2_valid && bus.pipe2_ready;
    s_valid = bus.noc2_valid_out;
    s_data  = bus.noc2_data_out;
    s_r1    = bus.pipe1_ready;
    s_r2    = bus.pipe2_ready;
    s_p2v   = bus.pipe2_valid;
    if (rst_n && bus.noc2_valid_out && bus.noc2_ready_out) obs_q.push_back(bus.noc2_data_out);
    if (t1) begin grant_q.push_back(1); grant_cyc.push_back(cyc); end
    if (t2) begin grant_q.push_back(2); grant_cyc.push_back(cyc); end
    @(posedge clk);
    #1;
    cyc++;
    if (t1) void'(p1_q.pop_front());
    if (t2) void'(p2_q.pop_front());
    drive();
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    p1_q.delete(); p2_q.delete(); exp_q.delete(); obs_q.delete();
    grant_q.delete(); grant_cyc.delete();
    bus.noc2_ready_out = 1'b1;
    drive();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    cyc = 0;
  endtask

  task automatic test_reset();
    bus.noc2_ready_out = 1'b1;
    p1_q.push_back({1'b1, 64'h11});
    p2_q.push_back({1'b1, 64'h22});
    drive();
    #2;
    checks++; if (bus.pipe1_ready !== 1'b0) begin failures++; $display("FAIL reset_p1_ready got=%b exp=0", bus.pipe1_ready); end
    checks++; if (bus.pipe2_ready !== 1'b0) begin failures++; $display("FAIL reset_p2_ready got=%b exp=0", bus.pipe2_ready); end
    checks++; if (bus.noc2_valid_out !== 1'b0) begin failures++; $display("FAIL reset_valid got=%b exp=0", bus.noc2_valid_out); end
    checks++; if (bus.noc2_data_out !== 64'h0) begin failures++; $display("FAIL reset_data got=%h exp=0", bus.noc2_data_out); end
    checks++; if (arb_owner !== 2'b00) begin failures++; $display("FAIL reset_owner got=%b exp=00", arb_owner); end
    checks++; if (msg_sent_cnt !== 16'h0) begin failures++; $display("FAIL reset_cnt got=%h exp=0", msg_sent_cnt); end
  endtask

  task automatic test_three_flit();
    logic [W-1:0] a[3] = '{64'hA0, 64'hA1, 64'hA2};
    logic [1:0]   own[3] = '{2'b10, 2'b10, 2'b00};
    apply_reset();
    for (int i = 0; i < 3; i++) p2_q.push_back({(i == 2), a[i]});
    drive();
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++; if (bus.noc2_valid_out !== 1'b1 || bus.noc2_data_out !== a[i]) begin
        failures++; $display("FAIL three_flit_data%0d got=%b/%h exp=1/%h", i, bus.noc2_valid_out, bus.noc2_data_out, a[i]); end
      checks++; if (arb_owner !== own[i]) begin failures++; $display("FAIL three_flit_owner%0d got=%b exp=%b", i, arb_owner, own[i]); end
    end
    checks++; if (msg_sent_cnt !== 16'd1) begin failures++; $display("FAIL three_flit_cnt got=%0d exp=1", msg_sent_cnt); end
  endtask

  task automatic test_starvation();
    int exp_g[15] = '{2,2,2,2,1,2,2,2,2,1,2,2,2,2,1};
    int i1 = 0, i2 = 0;
    apply_reset();
    for (int i = 0; i < 3; i++)  p1_q.push_back({1'b1, 64'h100 + 64'(i)});
    for (int i = 0; i < 12; i++) p2_q.push_back({1'b1, 64'h200 + 64'(i)});
    for (int i = 0; i < 15; i++) begin
      if (exp_g[i] == 1) begin exp_q.push_back(64'h100 + 64'(i1)); i1++; end
      else begin exp_q.push_back(64'h200 + 64'(i2)); i2++; end
    end
    drive();
    for (int n = 0; n < 40 && (p1_q.size() != 0 || p2_q.size() != 0); n++) tick();
    repeat (2) tick();
    checks++; if (grant_q.size() != 15) begin failures++; $display("FAIL starve_grant_count got=%0d exp=15", grant_q.size()); end
    for (int i = 0; i < 15 && i < grant_q.size(); i++) begin
      checks++; if (grant_q[i] != exp_g[i]) begin failures++; $display("FAIL starve_grant%0d got=p%0d exp=p%0d", i, grant_q[i], exp_g[i]); end
    end
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL starve_out_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      logic [W-1:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL starve_out got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_lock();
    int exp_g[5] = '{1,1,1,1,2};
    apply_reset();
    for (int i = 0; i < 4; i++) p1_q.push_back({(i == 3), 64'h300 + 64'(i)});
    drive();
    for (int n = 0; n < 10 && grant_q.size() == 0; n++) tick();
    p2_q.push_back({1'b1, 64'h400});
    drive();
    tick();
    checks++; if (s_p2v !== 1'b1 || s_r2 !== 1'b0) begin failures++; $display("FAIL lock_p2_ready got=v%b/r%b exp=v1/r0", s_p2v, s_r2); end
    for (int n = 0; n < 20 && (p1_q.size() != 0 || p2_q.size() != 0); n++) tick();
    checks++; if (grant_q.size() != 5) begin failures++; $display("FAIL lock_grant_count got=%0d exp=5", grant_q.size()); end
    for (int i = 0; i < 5 && i < grant_q.size(); i++) begin
      checks++; if (grant_q[i] != exp_g[i]) begin failures++; $display("FAIL lock_grant%0d got=p%0d exp=p%0d", i, grant_q[i], exp_g[i]); end
    end
    if (grant_cyc.size() == 5) begin
      checks++; if (grant_cyc[4] - grant_cyc[3] != 1) begin failures++; $display("FAIL lock_p2_gap got=%0d exp=1", grant_cyc[4] - grant_cyc[3]); end
    end
  endtask

  task automatic test_backpressure();
    apply_reset();
    for (int i = 0; i < 6; i++) begin
      p2_q.push_back({(i == 5), 64'h500 + 64'(i)});
      exp_q.push_back(64'h500 + 64'(i));
    end
    p1_q.push_back({1'b1, 64'h5FF});
    exp_q.push_back(64'h5FF);
    drive();
    repeat (2) tick();
    bus.noc2_ready_out = 1'b0;
    for (int n = 0; n < 5; n++) begin
      tick();
      checks++; if (s_valid !== 1'b1 || s_data !== 64'h501) begin failures++; $display("FAIL bp_hold%0d got=%b/%h exp=1/501", n, s_valid, s_data); end
      checks++; if (s_r1 !== 1'b0 || s_r2 !== 1'b0) begin failures++; $display("FAIL bp_ready%0d got=%b%b exp=00", n, s_r1, s_r2); end
    end
    bus.noc2_ready_out = 1'b1;
    for (int n = 0; n < 30 && (p1_q.size() != 0 || p2_q.size() != 0); n++) tick();
    repeat (2) tick();
    checks++; if (obs_q.size() != exp_q.size()) begin failures++; $display("FAIL bp_out_count got=%0d exp=%0d", obs_q.size(), exp_q.size()); end
    while (obs_q.size() != 0 && exp_q.size() != 0) begin
      logic [W-1:0] o, e;
      o = obs_q.pop_front(); e = exp_q.pop_front();
      checks++; if (o !== e) begin failures++; $display("FAIL bp_out got=%h exp=%h", o, e); end
    end
  endtask

  task automatic test_cnt_wrap();
    logic [15:0] exp_c[3] = '{16'hFFFF, 16'h0000, 16'h0001};
    apply_reset();
    for (int i = 0; i < 65534; i++) p2_q.push_back({1'b1, 64'(i)});
    drive();
    for (int n = 0; n < 70000 && p2_q.size() != 0; n++) tick();
    obs_q.delete();
    checks++; if (msg_sent_cnt !== 16'hFFFE) begin failures++; $display("FAIL wrap_pre got=%h exp=fffe", msg_sent_cnt); end
    for (int k = 0; k < 3; k++) begin
      p2_q.push_back({1'b1, 64'hC0 + 64'(k)});
      drive();
      for (int n = 0; n < 5 && p2_q.size() != 0; n++) tick();
      checks++; if (msg_sent_cnt !== exp_c[k]) begin failures++; $display("FAIL wrap_cnt%0d got=%h exp=%h", k, msg_sent_cnt, exp_c[k]); end
    end
  endtask

  task automatic test_reset_lock2();
    apply_reset();
    for (int i = 0; i < 3; i++) p2_q.push_back({(i == 2), 64'h600 + 64'(i)});
    drive();
    tick();
    checks++; if (arb_owner !== 2'b10 || bus.noc2_valid_out !== 1'b1) begin
      failures++; $display("FAIL rl2_pre got=%b/%b exp=10/1", arb_owner, bus.noc2_valid_out); end
    #1 rst_n = 1'b0;
    #1;
    checks++; if (bus.noc2_valid_out !== 1'b0 || bus.noc2_data_out !== 64'h0) begin
      failures++; $display("FAIL rl2_out got=%b/%h exp=0/0", bus.noc2_valid_out, bus.noc2_data_out); end
    checks++; if (arb_owner !== 2'b00 || msg_sent_cnt !== 16'h0) begin
      failures++; $display("FAIL rl2_owner_cnt got=%b/%h exp=00/0", arb_owner, msg_sent_cnt); end
    checks++; if (bus.pipe2_ready !== 1'b0) begin failures++; $display("FAIL rl2_p2_ready got=%b exp=0", bus.pipe2_ready); end
    p2_q.delete();
    p1_q.push_back({1'b1, 64'h7AA});
    drive();
    @(posedge clk);
    #1 rst_n = 1'b1;
    grant_q.delete();
    tick();
    checks++; if (grant_q.size() != 1 || grant_q[0] != 1) begin failures++; $display("FAIL rl2_idle_grant got=%0d exp=1 grant", grant_q.size()); end
    checks++; if (arb_owner !== 2'b00 || bus.noc2_data_out !== 64'h7AA) begin
      failures++; $display("FAIL rl2_after got=%b/%h exp=00/7aa", arb_owner, bus.noc2_data_out); end
  endtask

  initial begin
    test_reset();
    test_three_flit();
    test_starvation();
    test_lock();
    test_backpressure();
    test_cnt_wrap();
    test_reset_lock2();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
